// File: rtl/proc_trace_buffer_if.sv
// Capture, trigger-setup and readout signals of proc_trace_buffer.
// The master side drives samples and control; the slave side is the trace buffer.
interface proc_trace_buffer_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16
) ();
  localparam int AW = $clog2(DEPTH);

  logic [CHANNELS*WIDTH-1:0] ch_data;
  logic                      sample_en;
  logic                      arm;
  logic [WIDTH-1:0]          trig_value;
  logic [WIDTH-1:0]          trig_mask;
  logic [AW-1:0]             rd_addr;
  logic [CHANNELS*WIDTH-1:0] rd_data;
  logic                      armed;
  logic                      triggered;
  logic                      done;
  logic [AW:0]               fill;
  logic [AW-1:0]             trig_index;

  modport master (
    output ch_data, sample_en, arm, trig_value, trig_mask, rd_addr,
    input  rd_data, armed, triggered, done, fill, trig_index
  );

  modport slave (
    input  ch_data, sample_en, arm, trig_value, trig_mask, rd_addr,
    output rd_data, armed, triggered, done, fill, trig_index
  );
endinterface

// File: rtl/proc_trace_buffer.sv
// Circular trace buffer for processor datapath buses with a masked-compare trigger
// on channel 0, a programmable post-trigger window and registered random-access readout.
module proc_trace_buffer #(
  parameter int WIDTH        = 32,
  parameter int CHANNELS     = 4,
  parameter int DEPTH        = 16,
  parameter int POST_SAMPLES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  proc_trace_buffer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = CHANNELS * WIDTH;

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

  state_t        state, state_next;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   fill, fill_inc;
  logic [AW-1:0] post_cnt, post_next;
  logic [AW-1:0] trig_index, trig_idx_next;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic          trig_hit;
  logic [AW-1:0] rd_phys;
  logic          rd_valid;

  logic [DW-1:0] mem [DEPTH];

  assign trig_hit = ((bus.ch_data[WIDTH-1:0] ^ bus.trig_value) & bus.trig_mask) == '0;
  assign fill_inc = (fill == (AW+1)'(DEPTH)) ? fill : fill + (AW+1)'(1);

  // Oldest entry sits fill slots behind wr_ptr; a full buffer makes fill[AW-1:0] zero.
  assign rd_phys  = wr_ptr - fill[AW-1:0] + bus.rd_addr;
  assign rd_valid = {1'b0, bus.rd_addr} < fill;

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    wr_en         = 1'b0;
    post_next     = post_cnt;
    trig_idx_next = trig_index;
    if (bus.arm) begin
      state_next = ARMED;
    end else begin
      unique case (state)
        ARMED: if (bus.sample_en) begin
          wr_en = 1'b1;
          if (trig_hit) begin
            if (POST_SAMPLES == 0) begin
              state_next    = DONE;
              trig_idx_next = fill_inc[AW-1:0] - AW'(1);
            end else begin
              state_next = POST;
              post_next  = AW'(POST_SAMPLES);
            end
          end
        end
        POST: if (bus.sample_en) begin
          wr_en     = 1'b1;
          post_next = post_cnt - AW'(1);
          if (post_cnt == AW'(1)) begin
            state_next    = DONE;
            trig_idx_next = fill_inc[AW-1:0] - AW'(1) - AW'(POST_SAMPLES);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, which the read path relies on when a write hits the same entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      fill       <= '0;
      post_cnt   <= '0;
      trig_index <= '0;
      rd_data    <= '0;
    end else begin
      state      <= state_next;
      post_cnt   <= post_next;
      trig_index <= trig_idx_next;
      rd_data    <= rd_valid ? mem[rd_phys] : '0;
      if (bus.arm) begin
        wr_ptr <= '0;
        fill   <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        fill   <= fill_inc;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; its contents are only
  // meaningful below fill, which lets it map onto plain RAM.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) mem[wr_ptr] <= bus.ch_data;
  end

  assign bus.rd_data    = rd_data;
  assign bus.armed      = (state == ARMED) || (state == POST);
  assign bus.triggered  = (state == POST)  || (state == DONE);
  assign bus.done       = (state == DONE);
  assign bus.fill       = fill;
  assign bus.trig_index = trig_index;
endmodule

// File: tb/tb_proc_trace_buffer.sv
// Directed bench for proc_trace_buffer at DEPTH=8, POST_SAMPLES=2: capture, wrap,
// gated samples, re-arm, reset and masked triggers, all with hand-derived expectations.
module tb_proc_trace_buffer;
  localparam int WIDTH = 32;
  localparam int CH    = 4;
  localparam int DEPTH = 8;
  localparam int POST  = 2;
  localparam int AW    = $clog2(DEPTH);

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  proc_trace_buffer_if #(.WIDTH(WIDTH), .CHANNELS(CH), .DEPTH(DEPTH)) bus ();

  proc_trace_buffer #(
    .WIDTH(WIDTH), .CHANNELS(CH), .DEPTH(DEPTH), .POST_SAMPLES(POST)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Distinct content on every channel so a channel swap shows up in readback.
  function automatic logic [CH*WIDTH-1:0] make_bus(input logic [31:0] v);
    return {v ^ 32'hC3C3_0000, v + 32'h100, ~v, v};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_flags(input string name, input logic a, input logic t, input logic d,
                           input int f);
    n_checks++;
    if (bus.armed !== a || bus.triggered !== t || bus.done !== d || bus.fill !== (AW+1)'(f)) begin
      n_fail++;
      $display("FAIL %s: armed/trig/done/fill = %b/%b/%b/%0d, expected %b/%b/%b/%0d",
               name, bus.armed, bus.triggered, bus.done, bus.fill, a, t, d, f);
    end
  endtask

  task automatic chk_read(input string name, input int addr, input logic [CH*WIDTH-1:0] exp);
    bus.rd_addr = AW'(addr);
    step();
    n_checks++;
    if (bus.rd_data !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: rd_data = %h, expected %h", name, addr, bus.rd_data, exp);
    end
  endtask

  task automatic chk_tidx(input string name, input int exp);
    n_checks++;
    if (bus.trig_index !== AW'(exp)) begin
      n_fail++;
      $display("FAIL %s: trig_index = %0d, expected %0d", name, bus.trig_index, exp);
    end
  endtask

  task automatic do_arm();
    bus.arm = 1'b1; bus.sample_en = 1'b0;
    step();
    bus.arm = 1'b0;
  endtask

  task automatic sample(input logic [31:0] v, input logic en);
    bus.ch_data = make_bus(v); bus.sample_en = en;
    step();
    bus.sample_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.ch_data   = {$urandom, $urandom, $urandom, $urandom};
      bus.sample_en = 1'($urandom);
      bus.arm       = 1'($urandom);
      bus.rd_addr   = AW'($urandom);
      step();
    end
    chk_flags("reset_flags", 0, 0, 0, 0);
    n_checks++;
    if (bus.rd_data !== '0 || bus.trig_index !== '0) begin
      n_fail++;
      $display("FAIL reset_data: rd_data=%h trig_index=%0d, expected 0/0", bus.rd_data, bus.trig_index);
    end
    reset = 1'b0; bus.arm = 1'b0;
    for (int i = 0; i < 3; i++) sample(32'(i + 40), 1'b1);
    chk_flags("idle_no_write", 0, 0, 0, 0);
  endtask

  task automatic test_capture();
    bus.trig_value = 32'd5; bus.trig_mask = 32'hFFFF_FFFF;
    do_arm();
    chk_flags("armed", 1, 0, 0, 0);
    for (int v = 1; v <= 7; v++) begin
      sample(32'(v), 1'b1);
      if (v == 4) chk_flags("pre_trig", 1, 0, 0, 4);
      if (v == 5) chk_flags("trig_edge", 1, 1, 0, 5);
      if (v == 6) chk_flags("post1", 1, 1, 0, 6);
    end
    chk_flags("capture_done", 0, 1, 1, 7);
    chk_tidx("capture_tidx", 4);
    for (int a = 0; a < 7; a++) chk_read("capture_rd", a, make_bus(32'(a + 1)));
    chk_read("capture_rd_empty", 7, '0);
  endtask

  task automatic test_wrap();
    bus.trig_value = 32'd20;
    do_arm();
    for (int v = 1; v <= 21; v++) sample(32'(v), 1'b1);
    chk_flags("wrap_post", 1, 1, 0, 8);
    sample(32'd22, 1'b1);
    chk_flags("wrap_done", 0, 1, 1, 8);
    chk_tidx("wrap_tidx", 5);
    for (int a = 0; a < 8; a++) chk_read("wrap_rd", a, make_bus(32'(a + 15)));
  endtask

  task automatic test_gated_post();
    bus.trig_value = 32'd5;
    do_arm();
    for (int v = 1; v <= 5; v++) sample(32'(v), 1'b1);
    sample(32'd6, 1'b1);
    chk_flags("gate_en1", 1, 1, 0, 6);
    sample(32'd99, 1'b0);
    chk_flags("gate_off", 1, 1, 0, 6);
    sample(32'd7, 1'b1);
    chk_flags("gate_done", 0, 1, 1, 7);
    sample(32'd98, 1'b0);
    chk_flags("gate_hold", 0, 1, 1, 7);
    chk_tidx("gate_tidx", 4);
    for (int a = 0; a < 7; a++) chk_read("gate_rd", a, make_bus(32'(a + 1)));
  endtask

  task automatic test_rearm_and_reset();
    bus.trig_value = 32'd3;
    do_arm();
    for (int v = 1; v <= 3; v++) sample(32'(v), 1'b1);
    chk_flags("rearm_in_post", 1, 1, 0, 3);
    bus.arm = 1'b1;
    sample(32'd50, 1'b1);
    bus.arm = 1'b0;
    chk_flags("rearm", 1, 0, 0, 0);
    bus.trig_value = 32'd12;
    for (int v = 10; v <= 14; v++) sample(32'(v), 1'b1);
    chk_flags("rearm_done", 0, 1, 1, 5);
    chk_tidx("rearm_tidx", 2);
    chk_read("rearm_rd", 0, make_bus(32'd10));
    chk_read("rearm_rd", 4, make_bus(32'd14));

    bus.trig_value = 32'd2;
    do_arm();
    for (int v = 1; v <= 3; v++) sample(32'(v), 1'b1);
    chk_flags("rst_in_post", 1, 1, 0, 3);
    reset = 1'b1;
    sample(32'd4, 1'b1);
    chk_flags("rst_mid_post", 0, 0, 0, 0);
    n_checks++;
    if (bus.rd_data !== '0 || bus.trig_index !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_data: rd_data=%h trig_index=%0d, expected 0/0", bus.rd_data, bus.trig_index);
    end
    reset = 1'b0;
  endtask

  task automatic test_mask();
    bus.trig_mask = 32'h0000_FF00; bus.trig_value = 32'h0000_1200;
    do_arm();
    sample(32'h0011_2233, 1'b1);
    chk_flags("mask_miss", 1, 0, 0, 1);
    sample(32'h00AB_12CD, 1'b1);
    chk_flags("mask_hit", 1, 1, 0, 2);
    bus.trig_mask = 32'h0; bus.trig_value = 32'hDEAD_BEEF;
    do_arm();
    sample(32'd77, 1'b1);
    chk_flags("mask_zero", 1, 1, 0, 1);
    chk_read("mask_zero_rd", 0, make_bus(32'd77));
  endtask

  initial begin
    reset = 1'b1;
    bus.ch_data = '0; bus.sample_en = 1'b0; bus.arm = 1'b0;
    bus.trig_value = '0; bus.trig_mask = '0; bus.rd_addr = '0;
    test_reset();
    test_capture();
    test_wrap();
    test_gated_post();
    test_rearm_and_reset();
    test_mask();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/proc_trace_buffer.md
Name: proc_trace_buffer

Overview:
- Parametrised, synthesizable trace capture block for processor datapath buses (busa, busb, busw, x, and others).
- Records up to CHANNELS bus values per sampled cycle into a circular buffer, stops a programmable number of samples after a masked-compare trigger on channel 0, then supports random-access readout.
- Replaces passive waveform watching in processor benches and can be kept in silicon as a debug port.

Parameters:
- WIDTH, 32, bits per channel.
- CHANNELS, 4, number of traced buses; channel 0 is the trigger source.
- DEPTH, 16, buffer entries; power of two, >= 2.
- POST_SAMPLES, 4, samples stored after the trigger sample; must be < DEPTH.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ch_data  in  CHANNELS*WIDTH  traced buses; channel k occupies bits [k*WIDTH +: WIDTH].
- sample_en  in  1  capture ch_data this cycle when capturing.
- arm  in  1  single-cycle start/restart pulse.
- trig_value  in  WIDTH  trigger compare value.
- trig_mask  in  WIDTH  trigger compare mask; 1 = bit compared.
- rd_addr  in  log2(DEPTH)  logical read index; 0 = oldest stored sample.
- rd_data  out  CHANNELS*WIDTH  registered read data.
- armed  out  1  high in ARMED or POST.
- triggered  out  1  high in POST or DONE.
- done  out  1  high in DONE.
- fill  out  log2(DEPTH)+1  valid entries, 0..DEPTH.
- trig_index  out  log2(DEPTH)  logical index of the trigger sample; valid when done.

Behaviour:
- Reset, which takes priority over all other inputs:
  - State = IDLE.
  - wr_ptr, fill, post_cnt, trig_index and rd_data are all 0.
  - All flags are 0.
  - Buffer contents are don't-care.
- States: IDLE, ARMED, POST, DONE.
- arm pulse, in any state:
  - Next state = ARMED.
  - wr_ptr = 0, fill = 0, triggered = 0.
  - A sample_en in the same cycle is ignored.
- IDLE and DONE: no writes; buffer contents are held.
- ARMED, with sample_en = 1:
  - Write ch_data to mem[wr_ptr].
  - wr_ptr increments mod DEPTH (wrap-around).
  - fill increments, saturating at DEPTH.
- Trigger condition: ((ch_data[WIDTH-1:0] ^ trig_value) & trig_mask) == 0.
  - Evaluated only on written samples in ARMED.
  - The trigger sample itself is written.
  - trig_mask = 0 triggers on the first written sample.
- On trigger:
  - If POST_SAMPLES = 0, go to DONE.
  - Otherwise go to POST with post_cnt = POST_SAMPLES.
  - State, flags and post_cnt update on the same edge that writes the trigger sample.
- POST, with sample_en = 1:
  - Write as in ARMED and decrement post_cnt.
  - The write that brings post_cnt to 0 moves to DONE on that edge.
  - The trigger compare is not evaluated in POST.
- sample_en = 0 in ARMED or POST: no write, no counter change, state is held.
- trig_index: (fill - 1 - POST_SAMPLES) at entry to DONE.
  - Since fill saturates, an overwritten history keeps the trigger at DEPTH-1-POST_SAMPLES.
- Readout:
  - Physical address = (wr_ptr - fill + rd_addr) mod DEPTH, using the pre-edge wr_ptr and fill.
  - rd_data is registered with 1-cycle latency and updates every cycle in every state.
  - rd_addr >= fill gives rd_data = 0.
  - Reads during capture are permitted; a same-cycle write to the same physical entry returns the old contents.
- Memory is a register array, or inferred RAM with one write port and one read port.
- Flags and fill are registered and track state with no extra delay.

Test Plan:
- Parameters for all scenarios: WIDTH=32, CHANNELS=4, DEPTH=8, POST_SAMPLES=2.
- Reset held for 2 cycles with random inputs -> all outputs 0; state IDLE; sample_en without arm writes nothing (fill stays 0).
- Arm, then ch0 = 1,2,3,... with sample_en every cycle, trig_value=5, trig_mask=FFFFFFFF -> triggered the cycle after 5 is written; done after 7 is written; fill=7; trig_index=4; rd_addr 0..6 return ch0 = 1..7 one cycle later; rd_addr=7 returns 0.
- Wrap-around: same setup with trig_value=20 -> fill saturates at 8; done after 22; rd_addr 0..7 return 15..22; trig_index=5.
- sample_en toggled 1,0,1,0 during POST -> only enabled cycles write and count; done after exactly 2 enabled samples post-trigger; no duplicate entries.
- arm asserted mid-POST with sample_en=1 -> same-cycle sample dropped; fill=0; state ARMED; triggered=0; a later capture is correct. Reset asserted mid-POST -> IDLE with all outputs 0 on the next edge.
- trig_mask=0000FF00, trig_value=00001200, ch0 = 0xAB12CD -> triggers on that sample; trig_mask=0 triggers on the first sample after arm.
